shift_reg_ctrl: RTL and testbench

Sequencing controller for the N-bit serial-in shift register (`shift_reg`: clk, rst, ce, d, q).
- Accepts a parallel word over a valid/ready handshake.
- Serialises the word MSB-first into the shift register by driving its `ce` and `d`.
- After the last shift, reads back the register's parallel `q` and reports it with a loopback-match flag.
- Sits between a host/test sequencer and one `shift_reg` instance. Both blocks share clk and rst.

---
 rtl/shift_reg_pkg.sv | 10 +
 rtl/bit_down_counter.sv | 21 ++
 rtl/shift_reg_ctrl.sv | 70 +++++++
 tb/tb_shift_reg_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared state encoding and default width for the shift register controller
package shift_reg_pkg;
  localparam int N_DEF = 4;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/bit_down_counter.sv
// bit_down_counter: loadable down-counter with enable and zero/one flags
module bit_down_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero,
  output logic         one
);
  logic [W-1:0] cnt;
  // Saturates at zero so the count never wraps.
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
  assign one  = cnt == W'(1);
endmodule

// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: serialises a handshaked word MSB-first into a shift register and checks the loopback
module shift_reg_ctrl
  import shift_reg_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         pause,
  output logic         sr_ce,
  output logic         sr_d,
  input  logic [N-1:0] sr_q,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] rdata,
  output logic         match
);
  localparam logic [CW-1:0] N_LOAD = CW'(N);
  state_t       state;
  logic [N-1:0] word, shadow;
  logic         accept, step, cnt_zero, cnt_one;
  assign accept = state == IDLE && in_valid;
  assign step   = state == SHIFT && !pause;
  bit_down_counter #(.W(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .en    (step),
    .value (N_LOAD),
    .zero  (cnt_zero),
    .one   (cnt_one)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= IDLE;
      word   <= '0;
      shadow <= '0;
      rdata  <= '0;
      match  <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (in_valid) begin
            word   <= in_data;
            shadow <= in_data;
            state  <= SHIFT;
          end
        SHIFT:
          if (!pause) begin
            word <= word << 1;
            if (cnt_one || cnt_zero) state <= CAPTURE;
          end
        CAPTURE: begin
          rdata <= sr_q;
          match <= sr_q == shadow;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  assign in_ready = state == IDLE;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign sr_ce    = step;
  assign sr_d     = word[N-1];
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb_shift_reg_ctrl: drives shift_reg_ctrl wired to a behavioural shift register and checks against a frame model
module tb_shift_reg_ctrl;
  localparam int N = 4;
  logic         clk = 1'b0, rst = 1'b0;
  logic         in_valid = 1'b0, pause = 1'b0, stuck = 1'b0;
  logic [N-1:0] in_data = '0;
  logic         in_ready, sr_ce, sr_d, busy, done, match;
  logic [N-1:0] sr_q, rdata;
  int           errors = 0, checks = 0;

  shift_reg_ctrl #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .pause    (pause),
    .sr_ce    (sr_ce),
    .sr_d     (sr_d),
    .sr_q     (sr_q),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .match    (match)
  );

  always #5 clk = ~clk;

  // Attached shift register; 'stuck' models its d input shorted to 0.
  always_ff @(posedge clk or negedge rst)
    if (!rst) sr_q <= '0;
    else if (sr_ce) sr_q <= {sr_q[N-2:0], stuck ? 1'b0 : sr_d};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ce"}, sr_ce, 0);
    chk({tag, "_d"}, sr_d, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_match"}, match, 0);
  endtask

  // Entered at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after done.
  // vmode: 0 in_valid low during frame, 1 held high, 2 random pulses with random data.
  task automatic frame(input logic [N-1:0] data, input logic [15:0] pmask, input bit stk, input int vmode);
    bit q[$];
    int c;
    logic [N-1:0] exp_rdata;
    stuck = stk;
    in_data = data;
    in_valid = 1'b1;
    pause = 1'($urandom);
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    @(posedge clk) #1;
    for (int i = N - 1; i >= 0; i--) q.push_back(data[i]);
    c = 1;
    while (q.size() > 0 && c < 40) begin
      pause = c < 16 ? pmask[c] : 1'b0;
      in_valid = vmode == 1 ? 1'b1 : vmode == 2 ? 1'($urandom) : 1'b0;
      if (vmode == 2) in_data = N'($urandom);
      @(negedge clk);
      chk("shift_ce", sr_ce, !pause);
      if (!pause) chk("shift_d", sr_d, q[0]);
      chk("shift_busy", busy, 1);
      chk("shift_ready", in_ready, 0);
      chk("shift_done", done, 0);
      if (!pause) void'(q.pop_front());
      @(posedge clk) #1;
      c++;
    end
    if (c >= 40) chk("shift_timeout", c, 0);
    if (vmode != 1) in_valid = 1'b0;
    in_data = data;
    pause = 1'($urandom);
    @(negedge clk);
    chk("cap_ce", sr_ce, 0);
    chk("cap_busy", busy, 1);
    chk("cap_done", done, 0);
    @(posedge clk) #1;
    pause = 1'($urandom);
    exp_rdata = stk ? '0 : data;
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_ready", in_ready, 0);
    chk("done_rdata", rdata, exp_rdata);
    chk("done_match", match, exp_rdata == data);
    @(posedge clk) #1;
    pause = 1'b0;
  endtask

  initial begin
    #3;
    chk_reset_outputs("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    frame(4'b1011, 16'h0000, 0, 0);
    frame(4'b0110, 16'h000C, 0, 0);
    frame(4'b1111, 16'h0000, 0, 1);
    frame(4'b0000, 16'h0000, 0, 1);
    // Reset during the third SHIFT cycle.
    in_data = 4'b1100;
    in_valid = 1'b1;
    @(posedge clk) #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk) #1;
    #2 rst = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (3) begin
      @(negedge clk);
      chk("midrst_nodone", done, 0);
      chk("midrst_busy", busy, 0);
    end
    rst = 1'b1;
    @(posedge clk) #1;
    frame(4'b1001, 16'h0000, 0, 0);
    frame(4'b1010, 16'h0000, 1, 0);
    frame(4'b0101, 16'h0000, 0, 2);
    repeat (8) frame(N'($urandom), 16'($urandom) & 16'h0FFE, 0, int'($urandom_range(0, 2)));
    in_valid = 1'b0;
    @(negedge clk);
    chk("final_ready", in_ready, 1);
    chk("final_done", done, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
